// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle add/sub/logic/slt plus a WIDTH-cycle shift-add multiplier,
// with a valid/ready handshake on both the request and the result side.
module alu_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       ALUOp_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             illegal_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_zero;
  logic             r_illegal;

  logic [WIDTH-1:0] w_alu;
  logic             w_is_mul;
  logic             w_illegal;
  logic             w_accept;
  logic             w_mul_last;

  assign w_accept   = valid_i && (r_state == IDLE);
  assign w_mul_last = (r_cnt == CW'(WIDTH));

  // Operation decode and single-cycle result
  always_comb begin
    w_alu     = '0;
    w_is_mul  = 1'b0;
    w_illegal = 1'b0;
    case (ALUOp_i)
      2'b00: w_alu = data1_i + data2_i;
      2'b01: w_alu = data1_i - data2_i;
      2'b11: w_alu = data1_i | data2_i;
      2'b10: begin
        case (funct_i)
          6'b100000: w_alu = data1_i + data2_i;
          6'b100010: w_alu = data1_i - data2_i;
          6'b011000: w_is_mul = 1'b1;
          6'b100100: w_alu = data1_i & data2_i;
          6'b100101: w_alu = data1_i | data2_i;
          6'b100110: w_alu = data1_i ^ data2_i;
          6'b101010: w_alu = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
          default: begin
            w_alu     = data1_i & data2_i;
            w_illegal = 1'b1;
          end
        endcase
      end
      default: w_alu = '0;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = w_is_mul ? MUL : DONE;
        else          w_state_nxt = IDLE;
      end
      // WIDTH step cycles, then one cycle to latch the accumulator into the result
      MUL: begin
        if (w_mul_last) w_state_nxt = DONE;
        else            w_state_nxt = MUL;
      end
      DONE: begin
        if (ready_i) w_state_nxt = IDLE;
        else         w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath: operand capture, shift-add multiply, result/flag registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && w_is_mul) begin
            r_mcand  <= data1_i;
            r_mplier <= data2_i;
            r_acc    <= '0;
            r_cnt    <= '0;
          end else if (w_accept) begin
            r_data    <= w_alu;
            r_zero    <= (w_alu == '0);
            r_illegal <= w_illegal;
          end
        end
        MUL: begin
          if (w_mul_last) begin
            r_data    <= r_acc;
            r_zero    <= (r_acc == '0);
            r_illegal <= 1'b0;
          end else begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o   = (r_state == IDLE);
  assign valid_o   = (r_state == DONE);
  assign data_o    = r_data;
  assign zero_o    = r_zero;
  assign illegal_o = r_illegal;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed testbench for alu_seq_unit (WIDTH=32): each task drives one scenario and checks inline.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, ready_o, valid_o, ready_i, zero_o, illegal_o;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] d1, d2, data_o;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .ALUOp_i(aluop), .funct_i(funct), .data1_i(d1), .data2_i(d2),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .zero_o(zero_o), .illegal_o(illegal_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then drop valid_i; returns just after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    aluop = op; funct = fn; d1 = a; d2 = b; valid_i = 1'b1;
    tick;
    valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1;
    aluop = 2'b00; funct = 6'd0; d1 = 32'd5; d2 = 32'd7;
    tick; tick;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", ready_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid_o); end
    checks++; if (data_o !== 32'd0) begin errors++; $display("FAIL rst_data got %h exp 0", data_o); end
    checks++; if (zero_o !== 1'b0) begin errors++; $display("FAIL rst_zero got %b exp 0", zero_o); end
    checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b exp 0", illegal_o); end
    rst_i = 1'b1; valid_i = 1'b0;
    tick;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_no_accept got %b exp 0", valid_o); end
  endtask

  task automatic test_add_sub;
    ready_i = 1'b1;
    issue(2'b00, 6'd0, 32'd5, 32'd7);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", valid_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL add_ready got %b exp 0", ready_o); end
    checks++; if (data_o !== 32'd12) begin errors++; $display("FAIL add_data got %h exp c", data_o); end
    checks++; if (zero_o !== 1'b0 || illegal_o !== 1'b0) begin errors++; $display("FAIL add_flags got %b%b exp 00", zero_o, illegal_o); end
    tick;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL add_release got v%b r%b exp v0 r1", valid_o, ready_o); end
    issue(2'b01, 6'd0, 32'd9, 32'd9);
    checks++; if (data_o !== 32'd0 || zero_o !== 1'b1) begin errors++; $display("FAIL sub_zero got %h z%b exp 0 z1", data_o, zero_o); end
    tick;
    issue(2'b10, 6'b100010, 32'd3, 32'd5);
    checks++; if (data_o !== 32'hFFFFFFFE) begin errors++; $display("FAIL funct_sub got %h exp fffffffe", data_o); end
    tick;
    issue(2'b10, 6'b100000, 32'hFFFFFFFF, 32'd2);
    checks++; if (data_o !== 32'd1) begin errors++; $display("FAIL funct_add_wrap got %h exp 1", data_o); end
    tick;
  endtask

  task automatic test_logic;
    ready_i = 1'b1;
    issue(2'b10, 6'b100100, 32'hF0, 32'h3C);
    checks++; if (data_o !== 32'h30 || illegal_o !== 1'b0) begin errors++; $display("FAIL and got %h i%b exp 30 i0", data_o, illegal_o); end
    tick;
    issue(2'b10, 6'b100101, 32'hF0, 32'h3C);
    checks++; if (data_o !== 32'hFC) begin errors++; $display("FAIL or got %h exp fc", data_o); end
    tick;
    issue(2'b10, 6'b100110, 32'hF0, 32'h3C);
    checks++; if (data_o !== 32'hCC) begin errors++; $display("FAIL xor got %h exp cc", data_o); end
    tick;
    issue(2'b11, 6'b000000, 32'h0F, 32'h30);
    checks++; if (data_o !== 32'h3F) begin errors++; $display("FAIL aluop_or got %h exp 3f", data_o); end
    tick;
  endtask

  task automatic test_slt_illegal;
    ready_i = 1'b1;
    issue(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1);
    checks++; if (data_o !== 32'd1) begin errors++; $display("FAIL slt_neg got %h exp 1", data_o); end
    tick;
    issue(2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF);
    checks++; if (data_o !== 32'd0 || zero_o !== 1'b1) begin errors++; $display("FAIL slt_pos got %h z%b exp 0 z1", data_o, zero_o); end
    tick;
    issue(2'b10, 6'b111111, 32'hF0, 32'h3C);
    checks++; if (data_o !== 32'h30) begin errors++; $display("FAIL illegal_data got %h exp 30", data_o); end
    checks++; if (illegal_o !== 1'b1) begin errors++; $display("FAIL illegal_flag got %b exp 1", illegal_o); end
    tick;
    checks++; if (illegal_o !== 1'b1) begin errors++; $display("FAIL illegal_retain got %b exp 1", illegal_o); end
    issue(2'b00, 6'd0, 32'd1, 32'd1);
    checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL illegal_clear got %b exp 0", illegal_o); end
    tick;
  endtask

  task automatic test_mul;
    int n;
    ready_i = 1'b1;
    issue(2'b10, 6'b011000, 32'hFFFFFFFF, 32'd3);
    n = 0;
    while (valid_o !== 1'b1 && n < 40) begin
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL mul_busy cycle %0d got ready %b exp 0", n, ready_o); end
      tick; n++;
    end
    checks++; if (n !== 33) begin errors++; $display("FAIL mul_latency got %0d exp 33", n); end
    checks++; if (data_o !== 32'hFFFFFFFD) begin errors++; $display("FAIL mul_data got %h exp fffffffd", data_o); end
    checks++; if (zero_o !== 1'b0 || illegal_o !== 1'b0) begin errors++; $display("FAIL mul_flags got %b%b exp 00", zero_o, illegal_o); end
    tick;
    issue(2'b10, 6'b011000, 32'd7, 32'd6);
    n = 0;
    while (valid_o !== 1'b1 && n < 40) begin tick; n++; end
    checks++; if (n !== 33 || data_o !== 32'd42) begin errors++; $display("FAIL mul_small got %h after %0d exp 2a after 33", data_o, n); end
    tick;
  endtask

  task automatic test_hold;
    ready_i = 1'b0;
    issue(2'b00, 6'd0, 32'd5, 32'd7);
    for (int i = 0; i < 5; i++) begin
      valid_i = (i % 2 == 0); d1 = 32'd100 + i; d2 = 32'd200;
      tick;
      checks++; if (data_o !== 32'd12 || valid_o !== 1'b1 || ready_o !== 1'b0) begin
        errors++; $display("FAIL hold cycle %0d got %h v%b r%b exp c v1 r0", i, data_o, valid_o, ready_o);
      end
    end
    valid_i = 1'b0; ready_i = 1'b1;
    tick;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 32'd12) begin
      errors++; $display("FAIL hold_release got %h v%b r%b exp c v0 r1", data_o, valid_o, ready_o);
    end
    tick;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL hold_not_queued got %b exp 0", valid_o); end
    issue(2'b00, 6'd0, 32'd1, 32'd1);
    checks++; if (data_o !== 32'd2 || valid_o !== 1'b1) begin errors++; $display("FAIL hold_next got %h v%b exp 2 v1", data_o, valid_o); end
    tick;
  endtask

  task automatic test_reset_mid_mul;
    int seen;
    ready_i = 1'b1;
    issue(2'b10, 6'b011000, 32'd5, 32'd5);
    for (int i = 0; i < 9; i++) tick;
    rst_i = 1'b0;
    tick;
    rst_i = 1'b1;
    checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0 || data_o !== 32'd0) begin
      errors++; $display("FAIL midmul_reset got %h v%b r%b exp 0 v0 r1", data_o, valid_o, ready_o);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin tick; if (valid_o === 1'b1) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midmul_discard got %0d valid cycles exp 0", seen); end
    issue(2'b00, 6'd0, 32'd2, 32'd2);
    checks++; if (data_o !== 32'd4 || valid_o !== 1'b1) begin errors++; $display("FAIL midmul_after got %h v%b exp 4 v1", data_o, valid_o); end
    tick;
  endtask

  task automatic test_back_to_back;
    ready_i = 1'b1;
    aluop = 2'b00; d1 = 32'd1; d2 = 32'd1; valid_i = 1'b1;
    tick;
    checks++; if (data_o !== 32'd2 || valid_o !== 1'b1) begin errors++; $display("FAIL b2b_first got %h v%b exp 2 v1", data_o, valid_o); end
    d1 = 32'd3; d2 = 32'd4;
    tick;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 32'd2) begin
      errors++; $display("FAIL b2b_gap got %h v%b r%b exp 2 v0 r1", data_o, valid_o, ready_o);
    end
    tick;
    valid_i = 1'b0;
    checks++; if (data_o !== 32'd7 || valid_o !== 1'b1) begin errors++; $display("FAIL b2b_second got %h v%b exp 7 v1", data_o, valid_o); end
    tick;
  endtask

  initial begin
    rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    aluop = 2'b00; funct = 6'd0; d1 = 32'd0; d2 = 32'd0;
    test_reset;
    test_add_sub;
    test_logic;
    test_slt_illegal;
    test_mul;
    test_hold;
    test_reset_mid_mul;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
